// File: rtl/scaler_pkg.sv
// Shared definitions for the image scaler engine.
// Holds the scale-mode encodings seen on the mode port and the conversion
// FSM state type used by img_scaler_engine.
package scaler_pkg;

    // Encoding of the 2-bit mode port.
    typedef enum logic [1:0] {
        MODE_REPLICATE = 2'b00,  // zoom-in by pixel replication
        MODE_DECIMATE  = 2'b01,  // keep top-left pixel of each block
        MODE_CENTRE    = 2'b10,  // keep pixel nearest the block centre
        MODE_AVERAGE   = 2'b11   // mean of each FACTOR x FACTOR block
    } scale_mode_e;

    // Conversion control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } scaler_state_e;

    // Guard bits added above DATA_W in the block-average accumulator.
    localparam int unsigned ACC_GUARD_W = 4;

endpackage

// File: rtl/scaler_addr_gen.sv
// Coordinate counters and address arithmetic for the image scaler.
// Walks the output raster (oy, ox) and, in block-average mode, the
// FACTOR x FACTOR sub-block (by, bx) row-major. Each issued read produces a
// registered source address plus the destination address and block flags
// that travel with it down the ROM latency pipe.
//
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   clear        : zero all counters (conversion accepted)
//   issue        : issue one read this cycle and advance the counters
//   mode         : latched scale mode of the current conversion
//   rd_addr      : registered source address (drives rom_addr)
//   rd_vld       : rd_addr was issued in the previous cycle
//   wr_addr      : destination address associated with rd_addr
//   blk_first    : rd_addr is the first sample of its block
//   blk_last     : rd_addr completes its block (always 1 outside averaging)
//   last_rd      : the read issued this cycle is the final one (combinational)
module scaler_addr_gen
    import scaler_pkg::*;
#(
    parameter int unsigned SRC_W  = 160,
    parameter int unsigned SRC_H  = 120,
    parameter int unsigned FACTOR = 2,
    parameter int unsigned ADDR_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              issue,
    input  scale_mode_e       mode,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_vld,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              blk_first,
    output logic              blk_last,
    output logic              last_rd
);

    localparam int unsigned LOG_F = $clog2(FACTOR);

    localparam logic [ADDR_W-1:0] SRC_W_A = ADDR_W'(SRC_W);
    localparam logic [ADDR_W-1:0] HALF_F  = ADDR_W'(FACTOR / 2);
    localparam logic [ADDR_W-1:0] UP_W    = ADDR_W'(SRC_W * FACTOR);
    localparam logic [ADDR_W-1:0] UP_H    = ADDR_W'(SRC_H * FACTOR);
    localparam logic [ADDR_W-1:0] DN_W    = ADDR_W'(SRC_W / FACTOR);
    localparam logic [ADDR_W-1:0] DN_H    = ADDR_W'(SRC_H / FACTOR);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
    localparam logic [LOG_F-1:0]  BLK_MAX = LOG_F'(FACTOR - 1);
    localparam logic [LOG_F-1:0]  ONE_B   = LOG_F'(1);

    logic [ADDR_W-1:0] oy_q, oy_d, ox_q, ox_d;
    logic [LOG_F-1:0]  by_q, by_d, bx_q, bx_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic              rd_vld_q, rd_vld_d;
    logic              first_q, first_d, last_q, last_d;

    logic [ADDR_W-1:0] out_w, out_h, sy, sx;
    logic              blk_end, row_end;

    always_comb begin
        out_w = (mode == MODE_REPLICATE) ? UP_W : DN_W;
        out_h = (mode == MODE_REPLICATE) ? UP_H : DN_H;

        // Outside averaging every read is a complete one-sample block.
        blk_end = (mode != MODE_AVERAGE) || ((bx_q == BLK_MAX) && (by_q == BLK_MAX));
        row_end = (ox_q == out_w - ONE_A);
        last_rd = blk_end && row_end && (oy_q == out_h - ONE_A);

        sy = '0;
        sx = '0;
        case (mode)
            MODE_REPLICATE: begin
                sy = oy_q >> LOG_F;
                sx = ox_q >> LOG_F;
            end
            MODE_DECIMATE: begin
                sy = oy_q << LOG_F;
                sx = ox_q << LOG_F;
            end
            MODE_CENTRE: begin
                sy = (oy_q << LOG_F) + HALF_F;
                sx = (ox_q << LOG_F) + HALF_F;
            end
            MODE_AVERAGE: begin
                sy = (oy_q << LOG_F) + ADDR_W'(by_q);
                sx = (ox_q << LOG_F) + ADDR_W'(bx_q);
            end
        endcase

        oy_d = oy_q;
        ox_d = ox_q;
        by_d = by_q;
        bx_d = bx_q;
        if (clear) begin
            oy_d = '0;
            ox_d = '0;
            by_d = '0;
            bx_d = '0;
        end else if (issue) begin
            if (!blk_end) begin
                if (bx_q == BLK_MAX) begin
                    bx_d = '0;
                    by_d = by_q + ONE_B;
                end else begin
                    bx_d = bx_q + ONE_B;
                end
            end else begin
                bx_d = '0;
                by_d = '0;
                if (row_end) begin
                    ox_d = '0;
                    oy_d = last_rd ? '0 : oy_q + ONE_A;
                end else begin
                    ox_d = ox_q + ONE_A;
                end
            end
        end

        rd_vld_d  = issue;
        rd_addr_d = issue ? (sy * SRC_W_A + sx) : rd_addr_q;
        wr_addr_d = issue ? (oy_q * out_w + ox_q) : wr_addr_q;
        first_d   = (bx_q == '0) && (by_q == '0);
        last_d    = blk_end;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oy_q      <= '0;
            ox_q      <= '0;
            by_q      <= '0;
            bx_q      <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            rd_vld_q  <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            oy_q      <= oy_d;
            ox_q      <= ox_d;
            by_q      <= by_d;
            bx_q      <= bx_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            rd_vld_q  <= rd_vld_d;
            first_q   <= first_d;
            last_q    <= last_d;
        end
    end

    assign rd_addr   = rd_addr_q;
    assign rd_vld    = rd_vld_q;
    assign wr_addr   = wr_addr_q;
    assign blk_first = first_q;
    assign blk_last  = last_q;

endmodule

// File: rtl/img_scaler_engine.sv
// Image scaler engine: reads a SRC_W x SRC_H source image from a ROM with
// ROM_LAT cycles of read latency and writes the scaled image to a RAM in
// raster order (replicate, decimate, centre-sample or block-average).
//
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   start, mode          : one-cycle conversion request and scale mode
//   busy, done           : conversion in progress / finished (sticky)
//   rom_addr, rom_data   : source read port (data ROM_LAT cycles after addr)
//   ram_wraddr, ram_data,
//   ram_wren             : destination write port
module img_scaler_engine
    import scaler_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned SRC_W   = 160,
    parameter int unsigned SRC_H   = 120,
    parameter int unsigned FACTOR  = 2,
    parameter int unsigned ADDR_W  = 19,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren
);

    localparam int unsigned ACC_W  = DATA_W + ACC_GUARD_W;
    localparam int unsigned AVG_SH = $clog2(FACTOR * FACTOR);

    scaler_state_e state_q, state_d;
    scale_mode_e   mode_q, mode_d;

    logic              accept, issue, last_rd, pipe_empty;
    logic              ag_vld, ag_first, ag_last;
    logic [ADDR_W-1:0] ag_wr_addr;

    // Latency pipe: one stage per ROM cycle, aligned with rom_data at the tail.
    logic [ROM_LAT-1:0] pv_q, pv_d, pfirst_q, pfirst_d, plast_q, plast_d;
    logic [ADDR_W-1:0]  pwa_q [ROM_LAT];
    logic [ADDR_W-1:0]  pwa_d [ROM_LAT];

    logic [ACC_W-1:0]  acc_q, acc_d, sum;
    logic [ADDR_W-1:0] ram_wraddr_q, ram_wraddr_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic              ram_wren_q, ram_wren_d;

    scaler_addr_gen #(
        .SRC_W  (SRC_W),
        .SRC_H  (SRC_H),
        .FACTOR (FACTOR),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .clear     (accept),
        .issue     (issue),
        .mode      (mode_q),
        .rd_addr   (rom_addr),
        .rd_vld    (ag_vld),
        .wr_addr   (ag_wr_addr),
        .blk_first (ag_first),
        .blk_last  (ag_last),
        .last_rd   (last_rd)
    );

    // Control FSM
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        accept     = 1'b0;
        issue      = (state_q == ST_RUN);
        pipe_empty = !ag_vld && (pv_q == '0);
        case (state_q)
            ST_IDLE, ST_FIN: begin
                if (start) begin
                    accept  = 1'b1;
                    mode_d  = scale_mode_e'(mode);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_rd) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // The final write is on the port while this is evaluated,
                // so FIN starts with ram_wren already low.
                if (pipe_empty) state_d = ST_FIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_REPLICATE;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done = (state_q == ST_FIN);

    // Latency pipe shift
    always_comb begin
        pv_d[0]     = ag_vld;
        pfirst_d[0] = ag_first;
        plast_d[0]  = ag_last;
        pwa_d[0]    = ag_wr_addr;
        for (int unsigned i = 1; i < ROM_LAT; i++) begin
            pv_d[i]     = pv_q[i-1];
            pfirst_d[i] = pfirst_q[i-1];
            plast_d[i]  = plast_q[i-1];
            pwa_d[i]    = pwa_q[i-1];
        end
    end

    // Accumulate and write. The block's first sample bypasses the old
    // accumulator so consecutive blocks need no clearing cycle.
    always_comb begin
        sum          = (pfirst_q[ROM_LAT-1] ? '0 : acc_q) + ACC_W'(rom_data);
        acc_d        = acc_q;
        ram_wren_d   = 1'b0;
        ram_wraddr_d = ram_wraddr_q;
        ram_data_d   = ram_data_q;
        if (pv_q[ROM_LAT-1]) begin
            if (mode_q == MODE_AVERAGE) acc_d = sum;
            if (plast_q[ROM_LAT-1]) begin
                ram_wren_d   = 1'b1;
                ram_wraddr_d = pwa_q[ROM_LAT-1];
                ram_data_d   = (mode_q == MODE_AVERAGE) ? DATA_W'(sum >> AVG_SH) : rom_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pv_q         <= '0;
            pfirst_q     <= '0;
            plast_q      <= '0;
            for (int unsigned i = 0; i < ROM_LAT; i++) pwa_q[i] <= '0;
            acc_q        <= '0;
            ram_wraddr_q <= '0;
            ram_data_q   <= '0;
            ram_wren_q   <= 1'b0;
        end else begin
            pv_q         <= pv_d;
            pfirst_q     <= pfirst_d;
            plast_q      <= plast_d;
            for (int unsigned i = 0; i < ROM_LAT; i++) pwa_q[i] <= pwa_d[i];
            acc_q        <= acc_d;
            ram_wraddr_q <= ram_wraddr_d;
            ram_data_q   <= ram_data_d;
            ram_wren_q   <= ram_wren_d;
        end
    end

    assign ram_wraddr = ram_wraddr_q;
    assign ram_data   = ram_data_q;
    assign ram_wren   = ram_wren_q;

endmodule

// File: tb/tb_img_scaler_engine.sv
module tb_img_scaler_engine;

    localparam int SW = 4;
    localparam int SH = 4;
    localparam int F  = 2;
    localparam int AW = 19;
    localparam int DW = 8;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_r;
    logic [1:0]           mode_r;
    logic [1:0]           start_v;
    logic [1:0]           busy_v, done_v, wren_v;
    logic [1:0][AW-1:0]   rom_addr_v, wraddr_v;
    logic [1:0][DW-1:0]   rom_data_v, ram_data_v;

    logic [7:0] rom_mem [16];
    int         act_ram [256];
    wr_t        exp_q [$];

    int n_total = 0;
    int n_pass  = 0;
    int wr_count = 0;
    int exp_n = 0;
    int cyc = 0;
    int first_addr_cyc = -1;
    int first_wr_cyc = -1;
    int watch_addr = -1;

    function automatic logic [7:0] rom_rd(input logic [AW-1:0] a);
        if (a < AW'(16)) return rom_mem[a[3:0]];
        return 8'hEE;
    endfunction

    // Instance 0: ROM_LAT=1, instance 1: ROM_LAT=3. Only one runs at a time.
    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int LAT = (k == 0) ? 1 : 3;
        logic [DW-1:0] pipe [LAT];
        always @(posedge clk) begin
            pipe[0] <= rom_rd(rom_addr_v[k]);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign rom_data_v[k] = pipe[LAT-1];

        img_scaler_engine #(
            .DATA_W  (DW),
            .SRC_W   (SW),
            .SRC_H   (SH),
            .FACTOR  (F),
            .ADDR_W  (AW),
            .ROM_LAT (LAT)
        ) u_dut (
            .clk        (clk),
            .reset      (reset_r),
            .start      (start_v[k]),
            .mode       (mode_r),
            .busy       (busy_v[k]),
            .done       (done_v[k]),
            .rom_addr   (rom_addr_v[k]),
            .rom_data   (rom_data_v[k]),
            .ram_wraddr (wraddr_v[k]),
            .ram_data   (ram_data_v[k]),
            .ram_wren   (wren_v[k])
        );
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: expected writes in raster order from the scaling rules.
    task automatic build_expect(input logic [1:0] m);
        int ow, oh, v, sum;
        wr_t w;
        exp_q.delete();
        if (m == 2'b00) begin
            ow = SW * F; oh = SH * F;
        end else begin
            ow = SW / F; oh = SH / F;
        end
        for (int oy = 0; oy < oh; oy++) begin
            for (int ox = 0; ox < ow; ox++) begin
                case (m)
                    2'b00: v = rom_mem[(oy / F) * SW + ox / F];
                    2'b01: v = rom_mem[(oy * F) * SW + ox * F];
                    2'b10: v = rom_mem[(oy * F + F / 2) * SW + ox * F + F / 2];
                    default: begin
                        sum = 0;
                        for (int dy = 0; dy < F; dy++)
                            for (int dx = 0; dx < F; dx++)
                                sum += rom_mem[(oy * F + dy) * SW + ox * F + dx];
                        v = sum / (F * F);
                    end
                endcase
                w.addr = oy * ow + ox;
                w.data = v;
                exp_q.push_back(w);
            end
        end
        exp_n = exp_q.size();
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops one expected write per observed write.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (busy_v[k] && first_addr_cyc < 0 && watch_addr >= 0 && int'(rom_addr_v[k]) == watch_addr)
                first_addr_cyc = cyc;
            if (wren_v[k]) begin
                wr_t e;
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                check("wren_while_busy", int'(busy_v[k]), 1);
                check("write_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", int'(wraddr_v[k]), e.addr);
                    check("wr_data", int'(ram_data_v[k]), e.data);
                end
                if (int'(wraddr_v[k]) < 256) act_ram[int'(wraddr_v[k])] = int'(ram_data_v[k]);
                wr_count++;
            end
        end
    end

    task automatic run_conv(input int k, input logic [1:0] m, input int repulse, input int watch);
        bit finished;
        build_expect(m);
        for (int i = 0; i < 256; i++) act_ram[i] = -1;
        wr_count = 0;
        first_addr_cyc = -1;
        first_wr_cyc = -1;
        watch_addr = watch;
        mode_r = m;
        start_v[k] = 1'b1;
        finished = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            start_v[k] = (repulse > 0 && n == repulse);
            if (start_v[k]) mode_r = ~m;
            if (done_v[k]) begin
                finished = 1'b1;
                break;
            end
        end
        start_v[k] = 1'b0;
        check("run_finished", int'(finished), 1);
        check("write_count", wr_count, exp_n);
        check("queue_drained", exp_q.size(), 0);
        check("busy_after", int'(busy_v[k]), 0);
        check("done_after", int'(done_v[k]), 1);
        watch_addr = -1;
    endtask

    task automatic load_ramp();
        for (int a = 0; a < 16; a++) rom_mem[a] = 8'((a * 10) % 256);
    endtask

    initial begin
        int held;
        reset_r = 1'b1;
        start_v = '0;
        mode_r  = 2'b00;
        load_ramp();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_busy", int'(busy_v[k]), 0);
            check("reset_done", int'(done_v[k]), 0);
            check("reset_wren", int'(wren_v[k]), 0);
            check("reset_rom_addr", int'(rom_addr_v[k]), 0);
        end
        reset_r = 1'b0;
        @(negedge clk);

        // Centre sampling; first read is source (1,1) = address 5.
        run_conv(0, 2'b10, 0, 5);
        check("latency_lat1", first_wr_cyc - first_addr_cyc, 2);
        check("m10_ram0", act_ram[0], 50);
        check("m10_ram1", act_ram[1], 70);
        check("m10_ram2", act_ram[2], 130);
        check("m10_ram3", act_ram[3], 150);

        run_conv(1, 2'b10, 0, 5);
        check("latency_lat3", first_wr_cyc - first_addr_cyc, 4);

        run_conv(1, 2'b01, 0, -1);
        check("lat3_m01_ram0", act_ram[0], 0);
        check("lat3_m01_ram1", act_ram[1], 20);
        check("lat3_m01_ram2", act_ram[2], 80);
        check("lat3_m01_ram3", act_ram[3], 100);

        run_conv(0, 2'b00, 0, -1);
        check("m00_ram0", act_ram[0], 0);
        check("m00_ram1", act_ram[1], 0);
        check("m00_ram8", act_ram[8], 0);
        check("m00_ram9", act_ram[9], 0);
        check("m00_ram2", act_ram[2], 10);
        check("m00_ram63", act_ram[63], 150);

        run_conv(0, 2'b01, 0, -1);
        check("m01_ram0", act_ram[0], 0);
        check("m01_ram1", act_ram[1], 20);
        check("m01_ram2", act_ram[2], 80);
        check("m01_ram3", act_ram[3], 100);

        run_conv(0, 2'b11, 0, -1);
        check("m11_ram0", act_ram[0], 25);
        check("m11_ram1", act_ram[1], 45);
        check("m11_ram2", act_ram[2], 105);
        check("m11_ram3", act_ram[3], 125);

        // Start re-pulsed (with a different mode) while busy must be ignored.
        run_conv(0, 2'b00, 10, -1);

        // Reset at the 20th write of a replicate run.
        build_expect(2'b00);
        wr_count = 0;
        mode_r = 2'b00;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (wr_count >= 20) break;
            @(negedge clk);
            #2;
        end
        check("reset_at_write20", wr_count, 20);
        reset_r = 1'b1;
        #1;
        check("midrst_rom_addr", int'(rom_addr_v[0]), 0);
        check("midrst_wraddr", int'(wraddr_v[0]), 0);
        check("midrst_data", int'(ram_data_v[0]), 0);
        check("midrst_wren", int'(wren_v[0]), 0);
        check("midrst_busy", int'(busy_v[0]), 0);
        check("midrst_done", int'(done_v[0]), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset_r = 1'b0;
        held = wr_count;
        repeat (30) @(negedge clk);
        check("no_write_after_reset", wr_count, held);
        check("idle_busy", int'(busy_v[0]), 0);
        check("idle_done", int'(done_v[0]), 0);
        run_conv(0, 2'b00, 0, -1);

        // Randomised image contents and modes.
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < 16; a++) rom_mem[a] = 8'($urandom_range(0, 255));
            if (r < 6) run_conv(0, 2'($urandom_range(0, 3)), 0, -1);
            else run_conv(1, (r == 6) ? 2'b11 : 2'($urandom_range(0, 3)), 0, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
